snn_seq_ctrl: RTL and testbench

//  Top-level sequencer for the SNN digit classifier. Unpacks UART bytes into the
//  1-bit input-unit RAM (784 pixels, LSB first) and pulses start to the SNN core.

---
 rtl/snn_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_snn_seq_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_seq_ctrl.sv
// rtl/snn_seq_ctrl.sv - SNN classifier sequencer
// Unpacks UART bytes into the pixel RAM, starts the core, and sends the digit back as ASCII.
module snn_seq_ctrl #(
  parameter int             NUM_PIXELS   = 784,
  parameter int             ADDR_W       = 10,
  parameter logic [7:0]     ASCII_OFFSET = 8'h30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              we_input,
  output logic [ADDR_W-1:0] addr_input,
  output logic              d_input,
  output logic              snn_start,
  input  logic              snn_done,
  input  logic [3:0]        snn_digit,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic [7:0]        led,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [2:0] {
    S_LOAD, S_WRITE, S_START, S_WAIT_SNN, S_TX, S_WAIT_TX
  } state_t;

  localparam logic [ADDR_W-1:0] END_ADDR = ADDR_W'(NUM_PIXELS);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [3:0]          led_q, led_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                overrun_q, overrun_d;
  logic [ADDR_W-1:0]   addr_inc;

  assign addr_inc = addr_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_LOAD;
      addr_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      led_q     <= '0;
      tx_data_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      led_q     <= led_d;
      tx_data_q <= tx_data_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    led_d     = led_q;
    tx_data_d = tx_data_q;
    // Only LOAD accepts bytes; anything arriving elsewhere is lost and flagged.
    overrun_d = overrun_q | (rx_rdy && (state_q != S_LOAD));

    case (state_q)
      S_LOAD: begin
        if (rx_rdy) begin
          shift_d   = rx_data;
          bit_cnt_d = '0;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        shift_d   = {1'b0, shift_q[7:1]};
        addr_d    = addr_inc;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          state_d = (addr_inc == END_ADDR) ? S_START : S_LOAD;
        end
      end
      S_START: begin
        addr_d  = '0;
        state_d = S_WAIT_SNN;
      end
      S_WAIT_SNN: begin
        if (snn_done) begin
          led_d     = snn_digit;
          tx_data_d = ASCII_OFFSET + {4'h0, snn_digit};
          state_d   = S_TX;
        end
      end
      S_TX: begin
        state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (tx_done) state_d = S_LOAD;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  assign we_input   = (state_q == S_WRITE);
  assign d_input    = shift_q[0];
  assign addr_input = addr_q;
  assign snn_start  = (state_q == S_START);
  assign tx_start   = (state_q == S_TX);
  assign tx_data    = tx_data_q;
  assign led        = {4'h0, led_q};
  assign busy       = (state_q != S_LOAD);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_snn_seq_ctrl.sv
// tb/tb_snn_seq_ctrl.sv - directed bench for snn_seq_ctrl
module tb_snn_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_rdy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       we_input;
  logic [9:0] addr_input;
  logic       d_input;
  logic       snn_start;
  logic       snn_done = 1'b0;
  logic [3:0] snn_digit = 4'h0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done = 1'b0;
  logic [7:0] led;
  logic       busy;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int start_cnt = 0;
  int tx_cnt = 0;
  logic pix [1024];

  always #5 clk = ~clk;

  snn_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .we_input(we_input), .addr_input(addr_input), .d_input(d_input),
    .snn_start(snn_start), .snn_done(snn_done), .snn_digit(snn_digit),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .led(led), .busy(busy), .overrun(overrun)
  );

  // Passive log of RAM writes and pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (we_input) begin
      wr_cnt = wr_cnt + 1;
      pix[addr_input] = d_input;
    end
    if (snn_start) start_cnt = start_cnt + 1;
    if (tx_start) tx_cnt = tx_cnt + 1;
  end

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 11);
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00;
    snn_done = 1'b0; snn_digit = 4'h0; tx_done = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_rdy = 1'b1; rx_data = b;
    tick();
    rx_rdy = 1'b0;
  endtask

  task automatic send_spaced(input logic [7:0] b, input int gap);
    send_byte(b);
    repeat (gap - 1) tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({we_input, snn_start, tx_start, busy, overrun, d_input} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl: we/start/tx/busy/ovr/d=%b want 000000",
               {we_input, snn_start, tx_start, busy, overrun, d_input});
    end
    checks++;
    if (addr_input !== 10'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", addr_input); end
    checks++;
    if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_txdata: got %h want 00", tx_data); end
    checks++;
    if (led !== 8'h00) begin errors++; $display("FAIL reset_led: got %h want 00", led); end
  endtask

  task automatic test_single_byte();
    logic [7:0] b;
    int base;
    b = 8'hA5;
    do_reset();
    base = wr_cnt;
    send_byte(b);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (we_input !== 1'b1) begin errors++; $display("FAIL byte_we[%0d]: got %b want 1", i, we_input); end
      checks++;
      if (addr_input !== 10'(i)) begin errors++; $display("FAIL byte_addr[%0d]: got %0d want %0d", i, addr_input, i); end
      checks++;
      if (d_input !== b[i]) begin errors++; $display("FAIL byte_d[%0d]: got %b want %b", i, d_input, b[i]); end
      tick();
    end
    checks++;
    if ({we_input, busy} !== 2'b00) begin errors++; $display("FAIL byte_end_state: we/busy=%b want 00", {we_input, busy}); end
    checks++;
    if (addr_input !== 10'd8) begin errors++; $display("FAIL byte_end_addr: got %0d want 8", addr_input); end
    checks++;
    if (wr_cnt - base !== 8) begin errors++; $display("FAIL byte_wr_cnt: got %0d want 8", wr_cnt - base); end
  endtask

  task automatic test_full_image();
    int wbase, sbase;
    logic [7:0] got;
    do_reset();
    wbase = wr_cnt; sbase = start_cnt;
    for (int i = 0; i < 97; i++) send_spaced(pat(i), 20);
    checks++;
    if (start_cnt - sbase !== 0) begin errors++; $display("FAIL img_early_start: got %0d want 0", start_cnt - sbase); end
    send_byte(pat(97));
    repeat (7) tick();
    checks++;
    if (snn_start !== 1'b0) begin errors++; $display("FAIL img_start_n8: got %b want 0", snn_start); end
    tick();
    checks++;
    if (snn_start !== 1'b1) begin errors++; $display("FAIL img_start_n9: got %b want 1", snn_start); end
    tick();
    checks++;
    if (snn_start !== 1'b0) begin errors++; $display("FAIL img_start_width: got %b want 0", snn_start); end
    checks++;
    if (addr_input !== 10'd0) begin errors++; $display("FAIL img_addr_after: got %0d want 0", addr_input); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL img_busy_wait: got %b want 1", busy); end
    checks++;
    if (wr_cnt - wbase !== 784) begin errors++; $display("FAIL img_wr_cnt: got %0d want 784", wr_cnt - wbase); end
    checks++;
    if (start_cnt - sbase !== 1) begin errors++; $display("FAIL img_start_cnt: got %0d want 1", start_cnt - sbase); end
    for (int i = 0; i < 98; i++) begin
      for (int k = 0; k < 8; k++) got[k] = pix[i*8 + k];
      checks++;
      if (got !== pat(i)) begin errors++; $display("FAIL img_pixels[%0d]: got %h want %h", i, got, pat(i)); end
    end
  endtask

  task automatic test_classify();
    int tbase;
    tbase = tx_cnt;
    repeat (3) tick();
    checks++;
    if (tx_start !== 1'b0) begin errors++; $display("FAIL cls_idle_tx: got %b want 0", tx_start); end
    snn_done = 1'b1; snn_digit = 4'd7;
    tick();
    snn_done = 1'b0;
    checks++;
    if (tx_start !== 1'b1) begin errors++; $display("FAIL cls_tx_start: got %b want 1", tx_start); end
    checks++;
    if (tx_data !== 8'h37) begin errors++; $display("FAIL cls_tx_data: got %h want 37", tx_data); end
    checks++;
    if (led !== 8'h07) begin errors++; $display("FAIL cls_led: got %h want 07", led); end
    tick();
    checks++;
    if ({tx_start, busy} !== 2'b01) begin errors++; $display("FAIL cls_wait_tx: tx/busy=%b want 01", {tx_start, busy}); end
    checks++;
    if (tx_cnt - tbase !== 1) begin errors++; $display("FAIL cls_tx_cnt: got %0d want 1", tx_cnt - tbase); end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL cls_back_load: busy=%b want 0", busy); end
  endtask

  task automatic test_overrun();
    int wbase, sbase;
    logic [7:0] b;
    logic [7:0] got;
    b = 8'h3C;
    do_reset();
    wbase = wr_cnt; sbase = start_cnt;
    send_byte(b);
    tick(); tick();
    send_byte(8'hFF);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
    repeat (5) tick();
    checks++;
    if ({busy, addr_input} !== {1'b0, 10'd8}) begin
      errors++; $display("FAIL ovr_addr: busy=%b addr=%0d want 0/8", busy, addr_input);
    end
    checks++;
    if (wr_cnt - wbase !== 8) begin errors++; $display("FAIL ovr_wr_cnt: got %0d want 8", wr_cnt - wbase); end
    for (int k = 0; k < 8; k++) got[k] = pix[k];
    checks++;
    if (got !== b) begin errors++; $display("FAIL ovr_pixels: got %h want %h", got, b); end
    for (int i = 1; i < 98; i++) send_spaced(pat(i), 10);
    checks++;
    if (start_cnt - sbase !== 1) begin errors++; $display("FAIL ovr_start_cnt: got %0d want 1", start_cnt - sbase); end
    snn_done = 1'b1; snn_digit = 4'hA;
    tick();
    snn_done = 1'b0;
    checks++;
    if ({tx_start, tx_data, led} !== {1'b1, 8'h3A, 8'h0A}) begin
      errors++; $display("FAIL ovr_digit_a: tx=%b data=%h led=%h want 1/3a/0a", tx_start, tx_data, led);
    end
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++;
    if ({busy, overrun} !== 2'b01) begin errors++; $display("FAIL ovr_sticky: busy/ovr=%b want 01", {busy, overrun}); end
  endtask

  task automatic test_reset_mid();
    int sbase;
    sbase = start_cnt;
    for (int i = 0; i < 50; i++) send_spaced(pat(i), 10);
    send_byte(8'h81);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({we_input, snn_start, tx_start, busy, overrun} !== 5'b0) begin
      errors++; $display("FAIL rstmid_ctl: we/start/tx/busy/ovr=%b want 00000",
                         {we_input, snn_start, tx_start, busy, overrun});
    end
    checks++;
    if ({addr_input, tx_data, led} !== 26'd0) begin
      errors++; $display("FAIL rstmid_data: addr=%0d tx=%h led=%h want 0/00/00", addr_input, tx_data, led);
    end
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 97; i++) send_spaced(pat(i), 10);
    checks++;
    if (start_cnt - sbase !== 0) begin errors++; $display("FAIL rstmid_no_start: got %0d want 0", start_cnt - sbase); end
    checks++;
    if (addr_input !== 10'd776) begin errors++; $display("FAIL rstmid_addr: got %0d want 776", addr_input); end
    send_byte(pat(97));
    repeat (8) tick();
    checks++;
    if (snn_start !== 1'b1) begin errors++; $display("FAIL rstmid_start: got %b want 1", snn_start); end
    tick();
    snn_done = 1'b1; snn_digit = 4'd5;
    tick();
    snn_done = 1'b0;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++;
    if ({busy, led} !== {1'b0, 8'h05}) begin errors++; $display("FAIL rstmid_cls: busy=%b led=%h want 0/05", busy, led); end
  endtask

  task automatic test_done_in_load();
    int tbase;
    tbase = tx_cnt;
    snn_done = 1'b1; snn_digit = 4'd9;
    tick(); tick();
    snn_done = 1'b0;
    repeat (3) tick();
    checks++;
    if (tx_cnt - tbase !== 0) begin errors++; $display("FAIL load_done_tx: got %0d pulses want 0", tx_cnt - tbase); end
    checks++;
    if ({led, tx_data, busy} !== {8'h05, 8'h35, 1'b0}) begin
      errors++; $display("FAIL load_done_hold: led=%h tx=%h busy=%b want 05/35/0", led, tx_data, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_full_image();
    test_classify();
    test_overrun();
    test_reset_mid();
    test_done_in_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
